// File: rtl/systolic_skew_feeder_if.sv
// Operand-vector handshake into the systolic skew feeder: one N-word vector per transfer.
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 4
);
    logic [N*DATA_WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Feeds one edge of the systolic MAC array: lane i delayed i cycles, plus the shared
// load strobe with a flush of the skew pipeline and a one-cycle drain at the end of a pass.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    systolic_skew_feeder_if.slave   in_if,
    output logic [N*DATA_WIDTH-1:0] lane_out,
    output logic                    load,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    vec_count
);
    localparam int FC_WIDTH = (N > 1) ? $clog2(N) : 1;
    localparam logic [FC_WIDTH-1:0] FLUSH_LOAD = FC_WIDTH'(N - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [FC_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] vec_count_q, vec_count_d;
    logic                 ready;
    logic                 xfer;

    // Handshake and strobes decode from the state register alone.
    assign ready          = (state_q == S_IDLE) || (state_q == S_STREAM);
    assign in_if.in_ready = ready;
    assign load           = (state_q == S_STREAM) || (state_q == S_FLUSH);
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DRAIN);
    assign vec_count      = vec_count_q;
    assign xfer           = in_if.in_valid && ready;

    always_comb begin
        // NOTE: every variable gets a default before the branches, so no latch is inferred.
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        vec_count_d = vec_count_q;

        if (xfer) begin
            if (state_q == S_IDLE) begin
                vec_count_d = CNT_WIDTH'(1);
            end else if (!(&vec_count_q)) begin
                vec_count_d = vec_count_q + CNT_WIDTH'(1);
            end
        end

        case (state_q)
            S_IDLE, S_STREAM: begin
                if (xfer) begin
                    if (in_if.in_last) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_FLUSH: begin
                // N flush cycles let the deepest lane's last word reach the array with load high.
                if (flush_cnt_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_WIDTH'(1);
                end
            end
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            vec_count_q <= vec_count_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] word_d;
        logic [DATA_WIDTH-1:0] pipe_q [0:g];

        // Zeros are bubbles to the MAC, so idle and stalled edges simply shift in zero.
        assign word_d = xfer ? in_if.in_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;

        // NOTE: the delay stages are reset so an aborted pass leaves no stale words at the array edge.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k <= g; k++) begin
                    pipe_q[k] <= '0;
                end
            end else begin
                pipe_q[0] <= word_d;
                for (int k = 1; k <= g; k++) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
            end
        end

        assign lane_out[g*DATA_WIDTH +: DATA_WIDTH] = pipe_q[g];
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: an N=4 instance for the pass sequencing and
// a second N=1 instance for the degenerate edge length.
module tb_systolic_skew_feeder;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.DATA_WIDTH(DW), .N(N)) s_if ();
    systolic_skew_feeder_if #(.DATA_WIDTH(DW), .N(1)) s1_if ();

    logic [N*DW-1:0] lane_out;
    logic            load, busy, done;
    logic [CW-1:0]   vec_count;

    logic [DW-1:0]   lane_out1;
    logic            load1, busy1, done1;
    logic [CW-1:0]   vec_count1;

    systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_if     (s_if),
        .lane_out  (lane_out),
        .load      (load),
        .busy      (busy),
        .done      (done),
        .vec_count (vec_count)
    );

    systolic_skew_feeder #(.DATA_WIDTH(DW), .N(1), .CNT_WIDTH(CW)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_if     (s1_if),
        .lane_out  (lane_out1),
        .load      (load1),
        .busy      (busy1),
        .done      (done1),
        .vec_count (vec_count1)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l, input logic [N*DW-1:0] d);
        s_if.in_valid = v;
        s_if.in_last  = l;
        s_if.in_data  = d;
    endtask

    function automatic logic [N*DW-1:0] splat(input logic [DW-1:0] w);
        return {N{w}};
    endfunction

    function automatic logic [DW-1:0] lane(input int i);
        return lane_out[i*DW +: DW];
    endfunction

    initial begin
        logic [DW-1:0] exp_w;

        rst = 1'b0;
        drive(1'b0, 1'b0, '0);
        s1_if.in_valid = 1'b0;
        s1_if.in_last  = 1'b0;
        s1_if.in_data  = '0;

        #12;
        check("reset lane_out", lane_out, '0);
        check("reset load", load, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset vec_count", vec_count, '0);
        check("reset in_ready", s_if.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Single vector {4,3,2,1} with in_last from IDLE.
        drive(1'b1, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1});
        for (int t = 0; t <= 5; t++) begin
            step();
            if (t == 0) drive(1'b0, 1'b0, '0);
            for (int i = 0; i < N; i++) begin
                exp_w = (t == i) ? DW'(i + 1) : '0;
                check($sformatf("single t%0d lane%0d", t, i), lane(i), exp_w);
            end
            check($sformatf("single t%0d load", t), load, t <= 3);
            check($sformatf("single t%0d done", t), done, t == 4);
            check($sformatf("single t%0d busy", t), busy, t <= 4);
            check($sformatf("single t%0d in_ready", t), s_if.in_ready, t == 5);
        end
        check("single vec_count", vec_count, 1);

        // Three back-to-back vectors of 0x5, in_last on the third.
        for (int t = 0; t <= 7; t++) begin
            if (t < 3) drive(1'b1, t == 2, splat(32'h5));
            else       drive(1'b0, 1'b0, '0);
            step();
            for (int i = 0; i < N; i++) begin
                exp_w = (t >= i && t <= i + 2) ? 32'h5 : '0;
                check($sformatf("b2b t%0d lane%0d", t, i), lane(i), exp_w);
            end
            check($sformatf("b2b t%0d in_ready", t), s_if.in_ready, (t <= 1) || (t == 7));
            check($sformatf("b2b t%0d load", t), load, t <= 5);
            check($sformatf("b2b t%0d done", t), done, t == 6);
        end
        check("b2b vec_count", vec_count, 3);

        // Two vectors with one stalled cycle between them.
        for (int t = 0; t <= 7; t++) begin
            if (t == 0)      drive(1'b1, 1'b0, splat(32'h11));
            else if (t == 2) drive(1'b1, 1'b1, splat(32'h22));
            else             drive(1'b0, 1'b0, '0);
            step();
            for (int i = 0; i < N; i++) begin
                exp_w = (t == i) ? 32'h11 : (t == i + 2) ? 32'h22 : '0;
                check($sformatf("stall t%0d lane%0d", t, i), lane(i), exp_w);
            end
            check($sformatf("stall t%0d load", t), load, t <= 5);
            check($sformatf("stall t%0d done", t), done, t == 6);
        end
        check("stall vec_count", vec_count, 2);

        // Backpressure: a new vector held valid through FLUSH and DRAIN.
        for (int t = 0; t <= 7; t++) begin
            if (t == 0)      drive(1'b1, 1'b0, splat(32'h9));
            else if (t == 1) drive(1'b1, 1'b1, splat(32'h8));
            else             drive(1'b1, 1'b0, splat(32'hA));
            step();
            exp_w = (t == 0) ? 32'h9 : (t == 1) ? 32'h8 : (t == 7) ? 32'hA : '0;
            check($sformatf("bp t%0d lane0", t), lane(0), exp_w);
            check($sformatf("bp t%0d in_ready", t), s_if.in_ready, (t == 0) || (t >= 6));
            check($sformatf("bp t%0d vec_count", t), vec_count, (t == 0 || t == 7) ? 1 : 2);
            check($sformatf("bp t%0d done", t), done, t == 5);
            check($sformatf("bp t%0d busy", t), busy, t != 6);
        end

        // Asynchronous reset in the middle of the new STREAM pass.
        drive(1'b0, 1'b0, '0);
        #2;
        rst = 1'b0;
        #1;
        check("midreset lane_out", lane_out, '0);
        check("midreset load", load, 1'b0);
        check("midreset busy", busy, 1'b0);
        check("midreset done", done, 1'b0);
        check("midreset vec_count", vec_count, '0);
        check("midreset in_ready", s_if.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("postreset lane_out", lane_out, '0);

        // First transfer after reset starts a fresh pass.
        drive(1'b1, 1'b1, {32'd8, 32'd7, 32'd6, 32'd5});
        step();
        drive(1'b0, 1'b0, '0);
        check("fresh vec_count", vec_count, 1);
        check("fresh lane0", lane(0), 32'd5);
        check("fresh load", load, 1'b1);
        for (int t = 1; t <= 5; t++) begin
            step();
            check($sformatf("fresh t%0d done", t), done, t == 4);
            check($sformatf("fresh t%0d busy", t), busy, t <= 4);
        end
        check("fresh lane3 drained", lane(3), '0);

        // N=1 instance: a single vector of 7.
        s1_if.in_valid = 1'b1;
        s1_if.in_last  = 1'b1;
        s1_if.in_data  = 32'd7;
        for (int t = 0; t <= 2; t++) begin
            step();
            if (t == 0) begin
                s1_if.in_valid = 1'b0;
                s1_if.in_last  = 1'b0;
                s1_if.in_data  = '0;
            end
            check($sformatf("n1 t%0d lane_out", t), lane_out1, (t == 0) ? 32'd7 : 32'd0);
            check($sformatf("n1 t%0d load", t), load1, t == 0);
            check($sformatf("n1 t%0d done", t), done1, t == 1);
            check($sformatf("n1 t%0d busy", t), busy1, t <= 1);
            check($sformatf("n1 t%0d in_ready", t), s1_if.in_ready, t == 2);
        end
        check("n1 vec_count", vec_count1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
